line_mem_responder: RTL and testbench

//  Responder end of the 128-bit cache-line memory interface driven by the I/D caches
//  (mem_read/mem_write/mem_addr[31:4]/mem_wdata -> mem_rdata/mem_ready).

---
 rtl/line_mem_responder_if.sv | 20 ++
 rtl/line_mem_responder.sv | 142 ++++++++++++++
 tb/tb_line_mem_responder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/line_mem_responder_if.sv
// Cache-line memory bus between an I/D cache (master) and the line memory (slave).
// 128-bit lines addressed by byte address bits [31:4].
interface line_mem_responder_if;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/line_mem_responder.sv
// Line-wide memory responder with programmable latency (IDLE -> BUSY -> READY -> GAP).
// Optional LMR_STATS_EN adds saturating read/write completion counters.
module line_mem_responder #(
  parameter int LINE_AW = 8,
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  line_mem_responder_if.slave bus
`ifdef LMR_STATS_EN
  ,
  output logic [15:0] stat_rd_cnt,
  output logic [15:0] stat_wr_cnt
`endif
);

  localparam int         DEPTH = 1 << LINE_AW;
  localparam logic [7:0] LAT_L = 8'(LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY, READY, GAP} state_t;

  state_t               state_r;
  logic [7:0]           cnt_r;
  logic                 op_wr_r;
  logic [LINE_AW-1:0]   idx_r;
  logic [127:0]         wdata_r;
  logic [127:0]         rdata_r;
  logic                 ready_r;
  logic [127:0]         mem_r [0:DEPTH-1];

  logic                 req_s;
  logic                 enter_ready_s;
  logic                 op_wr_s;
  logic [LINE_AW-1:0]   idx_s;
  logic [127:0]         wdata_s;
  logic                 unused_addr_s;

  assign req_s         = bus.mem_read | bus.mem_write;
  assign unused_addr_s = ^bus.mem_addr[27:LINE_AW];
  assign bus.mem_ready = ready_r;
  assign bus.mem_rdata = rdata_r;

  // Operation about to complete: live inputs when accepting in IDLE, latched copy while BUSY
  always_comb begin
    enter_ready_s = 1'b0;
    op_wr_s       = op_wr_r;
    idx_s         = idx_r;
    wdata_s       = wdata_r;
    case (state_r)
      IDLE: begin
        op_wr_s       = bus.mem_write;
        idx_s         = bus.mem_addr[LINE_AW-1:0];
        wdata_s       = bus.mem_wdata;
        enter_ready_s = req_s && (LAT_L == 8'd1);
      end
      BUSY: begin
        if (cnt_r == 8'd1) begin
          enter_ready_s = 1'b1;
        end else begin
          enter_ready_s = 1'b0;
        end
      end
      default: enter_ready_s = 1'b0;
    endcase
  end

  // Line array: committed on the edge entering READY; contents intentionally not reset
  always_ff @(posedge clk) begin
    if (rst_n && enter_ready_s && op_wr_s) begin
      mem_r[idx_s] <= wdata_s;
    end
  end

  // Sequencer: accept, count down latency, one-cycle ready pulse, then one dead cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      op_wr_r <= 1'b0;
      idx_r   <= '0;
      wdata_r <= 128'd0;
      rdata_r <= 128'd0;
      ready_r <= 1'b0;
    end else begin
      ready_r <= enter_ready_s;
      if (enter_ready_s && !op_wr_s) begin
        rdata_r <= mem_r[idx_s];
      end
      case (state_r)
        IDLE: begin
          if (req_s) begin
            op_wr_r <= bus.mem_write;
            idx_r   <= bus.mem_addr[LINE_AW-1:0];
            wdata_r <= bus.mem_wdata;
            cnt_r   <= LAT_L - 8'd1;
            state_r <= (LAT_L == 8'd1) ? READY : BUSY;
          end
        end
        BUSY: begin
          cnt_r <= cnt_r - 8'd1;
          if (cnt_r == 8'd1) begin
            state_r <= READY;
          end
        end
        READY:   state_r <= GAP;
        GAP:     state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

`ifdef LMR_STATS_EN
  logic [15:0] stat_rd_cnt_r;
  logic [15:0] stat_wr_cnt_r;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // Completion counters, bumped on the edge entering READY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_cnt_r <= 16'd0;
      stat_wr_cnt_r <= 16'd0;
    end else if (enter_ready_s) begin
      if (op_wr_s) begin
        stat_wr_cnt_r <= sat_inc(stat_wr_cnt_r);
      end else begin
        stat_rd_cnt_r <= sat_inc(stat_rd_cnt_r);
      end
    end
  end

  assign stat_rd_cnt = stat_rd_cnt_r;
  assign stat_wr_cnt = stat_wr_cnt_r;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: LATENCY=4 instance checked against a line-array model,
// LATENCY=1 instance used for the ready-spacing check.
module tb_line_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  line_mem_responder_if if4 ();
  line_mem_responder_if if1 ();

`ifdef LMR_STATS_EN
  logic [15:0] rd4, wr4, rd1, wr1;
  line_mem_responder #(.LINE_AW(8), .LATENCY(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave),
                                                       .stat_rd_cnt(rd4), .stat_wr_cnt(wr4));
  line_mem_responder #(.LINE_AW(8), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave),
                                                       .stat_rd_cnt(rd1), .stat_wr_cnt(wr1));
`else
  line_mem_responder #(.LINE_AW(8), .LATENCY(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  line_mem_responder #(.LINE_AW(8), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
`endif

  // Reference model of the LATENCY=4 instance
  logic [127:0] model_mem [256];
  bit           model_vld [256];
  logic [127:0] model_rdata;
  int           model_rd, model_wr;

  task automatic model_op(input logic rd, input logic wr, input logic [27:0] addr,
                          input logic [127:0] wd);
    int idx;
    idx = int'(addr) % 256;
    if (wr) begin
      model_mem[idx] = wd;
      model_vld[idx] = 1'b1;
      model_wr = (model_wr < 65535) ? model_wr + 1 : 65535;
    end else if (rd) begin
      model_rdata = model_mem[idx];
      model_rd = (model_rd < 65535) ? model_rd + 1 : 65535;
    end
  endtask

  // One request on the LATENCY=4 port; returns ready latency, rdata seen, and one-cycle-wide flag
  task automatic req4(input logic rd, input logic wr, input logic [27:0] addr,
                      input logic [127:0] wd, input bit scramble,
                      output int lat, output logic [127:0] rdo, output bit narrow);
    lat = 0;
    @(negedge clk);
    if4.mem_read = rd; if4.mem_write = wr; if4.mem_addr = addr; if4.mem_wdata = wd;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (scramble) begin
        if4.mem_addr  = 28'($urandom);
        if4.mem_wdata = {4{$urandom}};
      end
      if (if4.mem_ready === 1'b1) begin
        lat = i;
        break;
      end
    end
    if4.mem_read = 1'b0; if4.mem_write = 1'b0;
    rdo = if4.mem_rdata;
    @(negedge clk);
    narrow = (if4.mem_ready === 1'b0);
  endtask

  task automatic test_reset();
    if4.mem_read = 1'b0; if4.mem_write = 1'b0; if4.mem_addr = 28'd0; if4.mem_wdata = 128'd0;
    if1.mem_read = 1'b0; if1.mem_write = 1'b0; if1.mem_addr = 28'd0; if1.mem_wdata = 128'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run += 2;
    if (if4.mem_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready4: got %b want 0", if4.mem_ready); end
    if (if4.mem_rdata !== 128'd0) begin tests_failed++; $display("FAIL reset_rdata4: got %h want 0", if4.mem_rdata); end
    tests_run += 2;
    if (if1.mem_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready1: got %b want 0", if1.mem_ready); end
    if (if1.mem_rdata !== 128'd0) begin tests_failed++; $display("FAIL reset_rdata1: got %h want 0", if1.mem_rdata); end
    rst_n = 1'b1;
    model_rdata = 128'd0; model_rd = 0; model_wr = 0;
  endtask

  task automatic test_write_read();
    int lat; logic [127:0] rdo; bit narrow;
    logic [127:0] pat;
    pat = 128'h0123456789abcdef0123456789abcdef;
    req4(1'b0, 1'b1, 28'h05, pat, 1'b0, lat, rdo, narrow);
    model_op(1'b0, 1'b1, 28'h05, pat);
    tests_run += 3;
    if (lat != 4) begin tests_failed++; $display("FAIL wr_latency: got %0d want 4", lat); end
    if (!narrow) begin tests_failed++; $display("FAIL wr_pulse_width: ready still high in next cycle, want 1-cycle pulse"); end
    if (rdo !== model_rdata) begin tests_failed++; $display("FAIL wr_rdata_hold: got %h want %h", rdo, model_rdata); end
    req4(1'b1, 1'b0, 28'h05, 128'd0, 1'b0, lat, rdo, narrow);
    model_op(1'b1, 1'b0, 28'h05, 128'd0);
    tests_run += 3;
    if (lat != 4) begin tests_failed++; $display("FAIL rd_latency: got %0d want 4", lat); end
    if (!narrow) begin tests_failed++; $display("FAIL rd_pulse_width: ready still high in next cycle, want 1-cycle pulse"); end
    if (rdo !== pat) begin tests_failed++; $display("FAIL rd_data: got %h want %h", rdo, pat); end
  endtask

  task automatic test_gap();
    int last, pulses;
    last = -1; pulses = 0;
    @(negedge clk);
    if1.mem_read = 1'b1; if1.mem_addr = 28'h3;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (if1.mem_ready === 1'b1) begin
        if (last >= 0) begin
          tests_run++;
          if (i - last != 3) begin tests_failed++; $display("FAIL gap_spacing: got %0d cycles want 3", i - last); end
        end
        last = i; pulses++;
      end
    end
    if1.mem_read = 1'b0;
    tests_run++;
    if (pulses != 10) begin tests_failed++; $display("FAIL gap_pulse_count: got %0d want 10", pulses); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_both();
    int lat; logic [127:0] rdo; bit narrow;
    logic [127:0] ones;
    ones = '1;
    req4(1'b1, 1'b1, 28'h10, ones, 1'b0, lat, rdo, narrow);
    model_op(1'b1, 1'b1, 28'h10, ones);
    tests_run += 3;
    if (lat != 4) begin tests_failed++; $display("FAIL both_latency: got %0d want 4", lat); end
    if (!narrow) begin tests_failed++; $display("FAIL both_single_ready: ready high two cycles, want one"); end
    if (rdo !== model_rdata) begin tests_failed++; $display("FAIL both_rdata_unchanged: got %h want %h", rdo, model_rdata); end
    req4(1'b1, 1'b0, 28'h10, 128'd0, 1'b0, lat, rdo, narrow);
    model_op(1'b1, 1'b0, 28'h10, 128'd0);
    tests_run++;
    if (rdo !== ones) begin tests_failed++; $display("FAIL both_readback: got %h want %h", rdo, ones); end
  endtask

  task automatic test_alias();
    int lat; logic [127:0] rdo; bit narrow;
    logic [127:0] a;
    a = 128'hA5A5_5A5A_DEAD_BEEF_CAFE_F00D_1234_5678;
    req4(1'b0, 1'b1, 28'h105, a, 1'b0, lat, rdo, narrow);
    model_op(1'b0, 1'b1, 28'h105, a);
    req4(1'b1, 1'b0, 28'h005, 128'd0, 1'b0, lat, rdo, narrow);
    model_op(1'b1, 1'b0, 28'h005, 128'd0);
    tests_run++;
    if (rdo !== a) begin tests_failed++; $display("FAIL alias_read: got %h want %h", rdo, a); end
  endtask

  task automatic test_random();
    int lat; logic [127:0] rdo; bit narrow;
    logic rd, wr; logic [27:0] addr; logic [127:0] wd; int kind;
    for (int n = 0; n < 24; n++) begin
      addr = {20'($urandom), 8'($urandom_range(32, 39))};
      wd   = {4{$urandom}};
      kind = $urandom_range(0, 2);
      rd = (kind != 1); wr = (kind != 0);
      if (!model_vld[int'(addr[7:0])]) begin rd = 1'b0; wr = 1'b1; end
      req4(rd, wr, addr, wd, bit'($urandom_range(0, 1)), lat, rdo, narrow);
      model_op(rd, wr, addr, wd);
      tests_run += 3;
      if (lat != 4) begin tests_failed++; $display("FAIL rand_latency[%0d]: got %0d want 4", n, lat); end
      if (!narrow) begin tests_failed++; $display("FAIL rand_pulse_width[%0d]: ready wider than one cycle", n); end
      if (rdo !== model_rdata) begin tests_failed++; $display("FAIL rand_rdata[%0d]: got %h want %h", n, rdo, model_rdata); end
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [127:0] rdo; bit narrow; bit seen_ready; bit rdata_bad;
    logic [127:0] b;
    b = 128'hBBBB_0000_1111_2222_3333_4444_5555_6666;
    req4(1'b0, 1'b1, 28'h20, b, 1'b0, lat, rdo, narrow);
    model_op(1'b0, 1'b1, 28'h20, b);
    @(negedge clk);
    if4.mem_write = 1'b1; if4.mem_addr = 28'h20; if4.mem_wdata = 128'hC0FFEE;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    if4.mem_write = 1'b0;
    seen_ready = 1'b0; rdata_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if4.mem_ready !== 1'b0) seen_ready = 1'b1;
      if (if4.mem_rdata !== 128'd0) rdata_bad = 1'b1;
    end
    rst_n = 1'b1;
    model_rdata = 128'd0; model_rd = 0; model_wr = 0;
    tests_run += 2;
    if (seen_ready) begin tests_failed++; $display("FAIL rstmid_no_ready: got ready=1 want 0"); end
    if (rdata_bad) begin tests_failed++; $display("FAIL rstmid_rdata_zero: got %h want 0", if4.mem_rdata); end
    req4(1'b1, 1'b0, 28'h20, 128'd0, 1'b0, lat, rdo, narrow);
    model_op(1'b1, 1'b0, 28'h20, 128'd0);
    tests_run += 2;
    if (lat != 4) begin tests_failed++; $display("FAIL rstmid_latency: got %0d want 4", lat); end
    if (rdo !== b) begin tests_failed++; $display("FAIL rstmid_old_value: got %h want %h", rdo, b); end
  endtask

`ifdef LMR_STATS_EN
  task automatic test_stats();
    int lat; logic [127:0] rdo; bit narrow;
    for (int n = 0; n < 5; n++) begin
      req4(n < 3, n >= 3, 28'h20, 128'h77, 1'b0, lat, rdo, narrow);
      model_op(n < 3, n >= 3, 28'h20, 128'h77);
    end
    tests_run += 2;
    if (rd4 !== 16'(model_rd)) begin tests_failed++; $display("FAIL stat_rd: got %0d want %0d", rd4, model_rd); end
    if (wr4 !== 16'(model_wr)) begin tests_failed++; $display("FAIL stat_wr: got %0d want %0d", wr4, model_wr); end
    @(negedge clk);
    force dut4.stat_rd_cnt_r = 16'hFFFF;
    @(negedge clk);
    release dut4.stat_rd_cnt_r;
    req4(1'b1, 1'b0, 28'h20, 128'd0, 1'b0, lat, rdo, narrow);
    tests_run++;
    if (rd4 !== 16'hFFFF) begin tests_failed++; $display("FAIL stat_rd_saturate: got %h want ffff", rd4); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_gap();
    test_both();
    test_alias();
    test_random();
    test_reset_mid();
`ifdef LMR_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
